ethstream_mux_tx: RTL and testbench

//  Multi-channel UDP transmit streamer; next generation of the single-channel ethstream TX path.
//  NUM_CH byte-wide AXI-stream sources each carry packets with a 2-byte little-endian length header.
//  A round-robin arbiter picks one channel per packet and forwards the payload to the byte-wide UDP core.

---
 rtl/ethstream_pkg.sv | 19 +
 rtl/ethstream_rr_arb.sv | 39 +++
 rtl/ethstream_mux_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_ethstream_mux_tx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethstream_pkg.sv
// Shared types and constants for the multi-channel ethstream UDP transmit path.
package ethstream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LSB_LENGTH,
      ST_MSB_LENGTH,
      ST_REQUEST,
      ST_STREAM,
      ST_DRAIN,
      ST_FINISH
   } state_t;

   localparam logic [1:0] RES_PEND = 2'b00;
   localparam logic [1:0] RES_OK   = 2'b01;

   localparam int HDR_BYTES = 2;

endpackage

// File: rtl/ethstream_rr_arb.sv
// Combinational round-robin pick: lowest requester at/after ptr, else lowest overall.
module ethstream_rr_arb
   import ethstream_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [IDX_W-1:0]  gnt_idx
);

   logic             hi_hit;
   logic             any_req;
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] lo_idx;

   always_comb begin
      hi_hit  = 1'b0;
      any_req = 1'b0;
      hi_idx  = '0;
      lo_idx  = '0;
      // descending scan so the lowest matching index wins in each class
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            any_req = 1'b1;
            lo_idx  = IDX_W'(i);
            if (i >= int'(ptr)) begin
               hi_hit = 1'b1;
               hi_idx = IDX_W'(i);
            end
         end
      end
      gnt_idx = hi_hit ? hi_idx : lo_idx;
      gnt     = any_req ? (NUM_CH'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/ethstream_mux_tx.sv
// Multi-channel UDP transmit streamer: round-robin packet mux with length header,
// length enforcement, result/timeout handling, link-drop recovery and status counters.
//
//  state       | meaning
//  IDLE        | waiting for link and a valid channel
//  LSB_LENGTH  | taking header length[7:0]
//  MSB_LENGTH  | taking header length[15:8]
//  REQUEST     | one-cycle UDP transmit request
//  STREAM      | forwarding payload, byte counter enforces length
//  DRAIN       | discarding channel bytes until tlast
//  FINISH      | waiting for UDP result or timeout
module ethstream_mux_tx
   import ethstream_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 32,
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  stream_linked,
   input  logic [31:0]           stream_ip_addr,
   input  logic [15:0]           stream_base_port,
   input  logic [8*NUM_CH-1:0]   s_axis_tdata,
   input  logic [NUM_CH-1:0]     s_axis_tvalid,
   input  logic [NUM_CH-1:0]     s_axis_tlast,
   output logic [NUM_CH-1:0]     s_axis_tready,
   output logic                  udp_out_start,
   output logic [7:0]            udp_out_data,
   output logic                  udp_out_valid,
   output logic                  udp_out_last,
   input  logic                  udp_out_ready,
   input  logic [1:0]            udp_out_result,
   output logic [31:0]           udp_out_dst_ip_addr,
   output logic [15:0]           udp_out_dst_port,
   output logic [15:0]           udp_out_length,
   output logic [CNT_W-1:0]      pkt_count,
   output logic [CNT_W-1:0]      err_count,
   output logic [IDX_W-1:0]      active_ch
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ch_q, rr_q, arb_idx, ch_next;
   logic [NUM_CH-1:0] arb_gnt;
   logic [15:0]      length_q, byte_cnt_q, port_q;
   logic [TMO_W-1:0] tmo_q;
   logic             started_q;
   logic [7:0]       tdata_ch;
   logic             tvalid_ch, tlast_ch;
   logic             grant, err_inc, pkt_inc;
   logic             len_lo_we, len_hi_we, cnt_load, cnt_dec;

   ethstream_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .req     (s_axis_tvalid),
      .ptr     (rr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign tdata_ch  = s_axis_tdata[8*ch_q +: 8];
   assign tvalid_ch = s_axis_tvalid[ch_q];
   assign tlast_ch  = s_axis_tlast[ch_q];
   assign ch_next   = (ch_q == IDX_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

   assign udp_out_dst_ip_addr = stream_ip_addr;
   assign udp_out_dst_port    = port_q;
   assign udp_out_length      = length_q;
   assign active_ch           = ch_q;

   always_comb begin
      state_d       = state_q;
      s_axis_tready = '0;
      udp_out_start = 1'b0;
      udp_out_valid = 1'b0;
      udp_out_last  = 1'b0;
      udp_out_data  = '0;
      grant         = 1'b0;
      err_inc       = 1'b0;
      pkt_inc       = 1'b0;
      len_lo_we     = 1'b0;
      len_hi_we     = 1'b0;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (stream_linked && (|arb_gnt)) begin
               grant   = 1'b1;
               state_d = ST_LSB_LENGTH;
            end
         end
         ST_LSB_LENGTH: begin
            s_axis_tready[ch_q] = 1'b1;
            if (tvalid_ch) begin
               len_lo_we = 1'b1;
               if (tlast_ch) begin
                  err_inc = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_MSB_LENGTH;
               end
            end
         end
         ST_MSB_LENGTH: begin
            s_axis_tready[ch_q] = 1'b1;
            if (tvalid_ch) begin
               len_hi_we = 1'b1;
               if (tlast_ch) begin
                  err_inc = 1'b1;
                  state_d = ST_IDLE;
               end else if ({tdata_ch, length_q[7:0]} == 16'd0) begin
                  err_inc = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_REQUEST;
               end
            end
         end
         ST_REQUEST: begin
            if (!stream_linked) begin
               err_inc = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               udp_out_start = 1'b1;
               cnt_load      = 1'b1;
               state_d       = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (!stream_linked) begin
               err_inc = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               udp_out_start       = 1'b1;
               udp_out_valid       = tvalid_ch;
               udp_out_data        = tdata_ch;
               udp_out_last        = tvalid_ch && ((byte_cnt_q == 16'd1) || tlast_ch);
               s_axis_tready[ch_q] = udp_out_ready;
               if (tvalid_ch && udp_out_ready) begin
                  if (byte_cnt_q == 16'd1) begin
                     // length reached: source must also end here, else the tail is discarded
                     if (tlast_ch) begin
                        state_d = ST_FINISH;
                     end else begin
                        err_inc = 1'b1;
                        state_d = ST_DRAIN;
                     end
                  end else if (tlast_ch) begin
                     err_inc = 1'b1;
                     state_d = ST_FINISH;
                  end else begin
                     cnt_dec = 1'b1;
                  end
               end
            end
         end
         ST_DRAIN: begin
            udp_out_start       = started_q;
            s_axis_tready[ch_q] = 1'b1;
            if (tvalid_ch && tlast_ch) begin
               state_d = started_q ? ST_FINISH : ST_IDLE;
            end
         end
         ST_FINISH: begin
            udp_out_start = 1'b1;
            if (!stream_linked) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end else if (udp_out_result == RES_OK) begin
               pkt_inc = 1'b1;
               state_d = ST_IDLE;
            end else if (udp_out_result != RES_PEND) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end else if (tmo_q == '0) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         ch_q       <= '0;
         rr_q       <= '0;
         port_q     <= '0;
         length_q   <= '0;
         byte_cnt_q <= '0;
         tmo_q      <= TMO_INIT;
         started_q  <= 1'b0;
         pkt_count  <= '0;
         err_count  <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            ch_q   <= arb_idx;
            port_q <= stream_base_port + 16'(arb_idx);
         end
         if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) rr_q <= ch_next;
         if (len_lo_we) length_q[7:0]  <= tdata_ch;
         if (len_hi_we) length_q[15:8] <= tdata_ch;
         if (cnt_load) byte_cnt_q <= length_q;
         else if (cnt_dec) byte_cnt_q <= byte_cnt_q - 16'd1;
         if (state_q != ST_FINISH) tmo_q <= TMO_INIT;
         else if (tmo_q != '0) tmo_q <= tmo_q - 1'b1;
         // remembers whether the UDP core was engaged, deciding DRAIN's exit and start
         if (state_q == ST_IDLE) started_q <= 1'b0;
         else if (state_q == ST_REQUEST) started_q <= stream_linked;
         else if ((state_q == ST_STREAM) && !stream_linked) started_q <= 1'b0;
         if (pkt_inc) pkt_count <= pkt_count + 1'b1;
         if (err_inc) err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_ethstream_mux_tx.sv
// Scoreboard bench for ethstream_mux_tx: per-channel expected bytes and expected packet headers.
module tb_ethstream_mux_tx;

   localparam int NUM_CH = 4;
   localparam int TMO    = 16;
   localparam int CNT_W  = 32;

   logic                clk = 1'b0;
   logic                aresetn = 1'b0;
   logic                stream_linked = 1'b0;
   logic [31:0]         stream_ip_addr = 32'hC0A8_0105;
   logic [15:0]         stream_base_port = 16'hFFFE;
   logic [8*NUM_CH-1:0] s_axis_tdata = '0;
   logic [NUM_CH-1:0]   s_axis_tvalid = '0;
   logic [NUM_CH-1:0]   s_axis_tlast = '0;
   logic [NUM_CH-1:0]   s_axis_tready;
   logic                udp_out_start, udp_out_valid, udp_out_last;
   logic [7:0]          udp_out_data;
   logic                udp_out_ready = 1'b1;
   logic [1:0]          udp_out_result = 2'b00;
   logic [31:0]         udp_out_dst_ip_addr;
   logic [15:0]         udp_out_dst_port, udp_out_length;
   logic [CNT_W-1:0]    pkt_count, err_count;
   logic [1:0]          active_ch;

   ethstream_mux_tx #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
      .clk                 (clk),
      .aresetn             (aresetn),
      .stream_linked       (stream_linked),
      .stream_ip_addr      (stream_ip_addr),
      .stream_base_port    (stream_base_port),
      .s_axis_tdata        (s_axis_tdata),
      .s_axis_tvalid       (s_axis_tvalid),
      .s_axis_tlast        (s_axis_tlast),
      .s_axis_tready       (s_axis_tready),
      .udp_out_start       (udp_out_start),
      .udp_out_data        (udp_out_data),
      .udp_out_valid       (udp_out_valid),
      .udp_out_last        (udp_out_last),
      .udp_out_ready       (udp_out_ready),
      .udp_out_result      (udp_out_result),
      .udp_out_dst_ip_addr (udp_out_dst_ip_addr),
      .udp_out_dst_port    (udp_out_dst_port),
      .udp_out_length      (udp_out_length),
      .pkt_count           (pkt_count),
      .err_count           (err_count),
      .active_ch           (active_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ch;
      logic [7:0] data;
      logic       last;
   } exp_byte_t;

   typedef struct {
      logic [15:0] port;
      logic [15:0] len;
   } exp_hdr_t;

   exp_byte_t dq[$];
   exp_hdr_t  hq[$];
   int        n_checks = 0;
   int        n_errors = 0;
   int        exp_pkt = 0;
   int        exp_err = 0;
   bit        abort = 1'b0;
   bit        res_auto = 1'b1;
   bit        ready_rand = 1'b0;
   int        res_delay = 3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic monitor();
      logic      start_d;
      exp_hdr_t  h;
      exp_byte_t e;
      bit        found;
      int        idx;
      start_d = 1'b0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            start_d = 1'b0;
         end else begin
            if (udp_out_start && !start_d) begin
               if (hq.size() == 0) chk("start_unexpected", udp_out_start, 0);
               else begin
                  h = hq.pop_front();
                  chk("dst_port", udp_out_dst_port, h.port);
                  chk("length", udp_out_length, h.len);
               end
            end
            start_d = udp_out_start;
            if (udp_out_valid && udp_out_ready) begin
               found = 1'b0;
               idx = 0;
               for (int i = 0; i < dq.size(); i++) begin
                  if (!found && dq[i].ch == int'(active_ch)) begin
                     found = 1'b1;
                     idx = i;
                  end
               end
               if (!found) chk("byte_unexpected", udp_out_valid, 0);
               else begin
                  e = dq[idx];
                  dq.delete(idx);
                  chk("data", udp_out_data, e.data);
                  chk("last", udp_out_last, e.last);
               end
            end
         end
      end
   endtask

   task automatic responder();
      forever begin
         @(negedge clk);
         if (aresetn && res_auto && udp_out_valid && udp_out_ready && udp_out_last) begin
            repeat (res_delay) @(posedge clk);
            #1 udp_out_result = 2'b01;
            @(posedge clk);
            #1 udp_out_result = 2'b00;
         end
      end
   endtask

   task automatic ready_gen();
      forever begin
         @(posedge clk);
         #1 udp_out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic put_byte(input int ch, input logic [7:0] d, input logic l);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      s_axis_tdata[8*ch +: 8] = d;
      s_axis_tlast[ch] = l;
      s_axis_tvalid[ch] = 1'b1;
      while (!acc && !abort && n < 400) begin
         @(negedge clk);
         if (s_axis_tready[ch] && !abort) acc = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      s_axis_tvalid[ch] = 1'b0;
      s_axis_tlast[ch] = 1'b0;
      if (!abort) chk($sformatf("accept_ch%0d", ch), acc, 1);
   endtask

   task automatic send_pkt(input int ch, input logic [15:0] len, input int n, input int seed,
                           input int fwd, input logic fwd_last);
      exp_byte_t e;
      for (int i = 0; i < fwd; i++) begin
         e.ch = ch;
         e.data = 8'(seed + i);
         e.last = (i == fwd - 1) ? fwd_last : 1'b0;
         dq.push_back(e);
      end
      put_byte(ch, len[7:0], 1'b0);
      put_byte(ch, len[15:8], 1'b0);
      for (int i = 0; i < n; i++) put_byte(ch, 8'(seed + i), (i == n - 1));
   endtask

   task automatic expect_hdr(input int ch, input logic [15:0] len);
      exp_hdr_t h;
      h.port = stream_base_port + 16'(ch);
      h.len = len;
      hq.push_back(h);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((udp_out_start || s_axis_tready != '0) && n < 300);
      chk("done_start", udp_out_start, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic end_test(input string name);
      chk({name, "_pkt"}, pkt_count, exp_pkt);
      chk({name, "_err"}, err_count, exp_err);
      chk({name, "_dq"}, dq.size(), 0);
      chk({name, "_hq"}, hq.size(), 0);
      chk({name, "_tready"}, s_axis_tready, 0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      s_axis_tvalid = '0;
      s_axis_tlast = '0;
      dq.delete();
      hq.delete();
      exp_pkt = 0;
      exp_err = 0;
      repeat (2) @(posedge clk);
      #1 aresetn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  hit;
      fork
         monitor();
         responder();
         ready_gen();
      join_none

      stream_linked = 1'b1;
      @(negedge clk);
      chk("rst_start", udp_out_start, 0);
      chk("rst_valid", udp_out_valid, 0);
      chk("rst_last", udp_out_last, 0);
      chk("rst_data", udp_out_data, 0);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_port", udp_out_dst_port, 0);
      chk("rst_len", udp_out_length, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_ch", active_ch, 0);
      chk("rst_ip", udp_out_dst_ip_addr, 32'hC0A8_0105);
      @(posedge clk);
      #1 aresetn = 1'b1;

      // basic packet on ch1, result after 3 cycles
      res_delay = 3;
      expect_hdr(1, 16'd4);
      send_pkt(1, 16'd4, 4, 8'h10, 4, 1'b1);
      exp_pkt++;
      wait_done();
      end_test("basic");

      // round robin from pointer 0 with ready bubbles; port wraps for ch2
      do_reset();
      ready_rand = 1'b1;
      expect_hdr(0, 16'd3);
      expect_hdr(2, 16'd5);
      expect_hdr(0, 16'd2);
      fork
         begin
            send_pkt(0, 16'd3, 3, 8'h20, 3, 1'b1);
            send_pkt(0, 16'd2, 2, 8'h30, 2, 1'b1);
         end
         send_pkt(2, 16'd5, 5, 8'h40, 5, 1'b1);
      join
      ready_rand = 1'b0;
      exp_pkt += 3;
      wait_done();
      end_test("rr");

      // oversize: header 3, source sends 5
      res_delay = 6;
      expect_hdr(3, 16'd3);
      send_pkt(3, 16'd3, 5, 8'h50, 3, 1'b1);
      exp_pkt++;
      exp_err++;
      wait_done();
      end_test("oversize");

      // short: header 5, tlast on byte 3
      res_delay = 3;
      expect_hdr(0, 16'd5);
      send_pkt(0, 16'd5, 3, 8'h60, 3, 1'b1);
      exp_pkt++;
      exp_err++;
      wait_done();
      end_test("short");

      // zero length header
      send_pkt(2, 16'd0, 2, 8'h70, 0, 1'b0);
      exp_err++;
      wait_done();
      end_test("zero_len");

      // result never arrives
      res_auto = 1'b0;
      expect_hdr(1, 16'd2);
      send_pkt(1, 16'd2, 2, 8'h80, 2, 1'b1);
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (!udp_out_start) break;
         n++;
      end
      chk("timeout_cycles", n, TMO);
      exp_err++;
      res_auto = 1'b1;
      wait_done();
      end_test("timeout");

      // link drop after payload byte 2 of 8
      expect_hdr(2, 16'd8);
      fork
         send_pkt(2, 16'd8, 8, 8'h90, 2, 1'b0);
         begin
            n = 0;
            hit = 1'b0;
            while (!hit && n < 200) begin
               @(negedge clk);
               n++;
               if (udp_out_valid && udp_out_ready && udp_out_data == 8'h91) hit = 1'b1;
            end
            chk("drop_seen", hit, 1);
            @(posedge clk);
            #1 stream_linked = 1'b0;
            @(negedge clk);
            chk("drop_start", udp_out_start, 0);
         end
      join
      exp_err++;
      wait_done();
      s_axis_tvalid[3] = 1'b1;
      repeat (3) @(negedge clk);
      chk("unlinked_hold", s_axis_tready, 0);
      s_axis_tvalid[3] = 1'b0;
      stream_linked = 1'b1;
      end_test("link_drop");

      // reset mid-stream, then resume
      expect_hdr(3, 16'd8);
      fork
         send_pkt(3, 16'd8, 8, 8'hA0, 8, 1'b1);
         begin
            n = 0;
            hit = 1'b0;
            while (!hit && n < 200) begin
               @(negedge clk);
               n++;
               if (udp_out_valid && udp_out_ready && udp_out_data == 8'hA2) hit = 1'b1;
            end
            chk("rst_mid_seen", hit, 1);
            @(posedge clk);
            #1 aresetn = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            chk("rst_mid_start", udp_out_start, 0);
            chk("rst_mid_valid", udp_out_valid, 0);
            chk("rst_mid_tready", s_axis_tready, 0);
            chk("rst_mid_pkt", pkt_count, 0);
            chk("rst_mid_err", err_count, 0);
            chk("rst_mid_len", udp_out_length, 0);
            chk("rst_mid_port", udp_out_dst_port, 0);
            repeat (3) @(posedge clk);
            #1 aresetn = 1'b1;
         end
      join
      abort = 1'b0;
      dq.delete();
      hq.delete();
      exp_pkt = 0;
      exp_err = 0;
      expect_hdr(1, 16'd3);
      send_pkt(1, 16'd3, 3, 8'hB0, 3, 1'b1);
      exp_pkt = 1;
      wait_done();
      end_test("resume");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
